// File: rtl/pipe_stage_buffer.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid,
// synchronous flush and bubble insertion (control field zeroed when empty).
module pipe_stage_buffer #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 102,
  parameter int unsigned SKID   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e              state_q;
  logic              valid_q;
  logic              rdy_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [15:0]       stall_q;
  logic [15:0]       stall_d;
  logic              in_fire;
  logic              out_fire;

  // SKID=0 has no second slot, so it may only accept while draining.
  assign in_ready  = (SKID != 0) ? rdy_q : (!valid_q | out_ready);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = valid_q & out_ready;

  assign out_valid = valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

  always_comb begin
    stall_d = stall_q;
    if (valid_q && !out_ready && (stall_q != '1)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      valid_q     <= 1'b0;
      rdy_q       <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_q     <= '0;
    end else begin
      stall_q <= stall_d;
      if (flush) begin
        // Data registers are intentionally left untouched; only control is bubbled.
        state_q     <= EMPTY;
        valid_q     <= 1'b0;
        rdy_q       <= 1'b1;
        main_ctrl_q <= '0;
        skid_ctrl_q <= '0;
      end else begin
        case (state_q)
          EMPTY: begin
            if (in_fire) begin
              main_ctrl_q <= in_ctrl;
              main_data_q <= in_data;
              valid_q     <= 1'b1;
              state_q     <= ONE;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_ctrl_q <= in_ctrl;
              main_data_q <= in_data;
            end else if (in_fire) begin
              // Only reachable with SKID=1: downstream stalled, park input in skid.
              skid_ctrl_q <= in_ctrl;
              skid_data_q <= in_data;
              rdy_q       <= 1'b0;
              state_q     <= TWO;
            end else if (out_fire) begin
              main_ctrl_q <= '0;
              valid_q     <= 1'b0;
              state_q     <= EMPTY;
            end
          end
          TWO: begin
            if (out_fire) begin
              main_ctrl_q <= skid_ctrl_q;
              main_data_q <= skid_data_q;
              rdy_q       <= 1'b1;
              state_q     <= ONE;
            end
          end
          default: begin
            state_q     <= EMPTY;
            valid_q     <= 1'b0;
            rdy_q       <= 1'b1;
            main_ctrl_q <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer: one SKID=1 and one SKID=0 instance.
module tb_pipe_stage_buffer;

  localparam int unsigned CW = 16;
  localparam int unsigned DW = 102;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          f1, iv1, ir1, ov1, or1;
  logic [CW-1:0] ic1, oc1;
  logic [DW-1:0] id1, od1;
  logic [1:0]    occ1;
  logic [15:0]   st1;

  logic          f0, iv0, ir0, ov0, or0;
  logic [CW-1:0] ic0, oc0;
  logic [DW-1:0] id0, od0;
  logic [1:0]    occ0;
  logic [15:0]   st0;

  int total = 0;
  int bad   = 0;

  pipe_stage_buffer #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_s1 (
    .clock(clock), .reset(reset), .flush(f1),
    .in_valid(iv1), .in_ready(ir1), .in_ctrl(ic1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_ctrl(oc1), .out_data(od1),
    .occupancy(occ1), .stall_cnt(st1)
  );

  pipe_stage_buffer #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_s0 (
    .clock(clock), .reset(reset), .flush(f0),
    .in_valid(iv0), .in_ready(ir0), .in_ctrl(ic0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_ctrl(oc0), .out_data(od0),
    .occupancy(occ0), .stall_cnt(st0)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive1(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    iv1 = v; ic1 = c; id1 = d;
  endtask

  initial begin
    f1 = 0; iv1 = 0; or1 = 1; ic1 = '0; id1 = '0;
    f0 = 0; iv0 = 0; or0 = 1; ic0 = '0; id0 = '0;

    // Reset state
    #1 reset = 1'b1;
    #2;
    chk("rst_occ", occ1, 0);
    chk("rst_ov", ov1, 0);
    chk("rst_oc", oc1, 0);
    chk("rst_od", od1, 0);
    chk("rst_stall", st1, 0);
    chk("rst_ir", ir1, 1);
    chk("rst_ir_s0", ir0, 1);
    reset = 1'b0;

    // Streaming, out_ready=1
    or1 = 1;
    for (int i = 1; i <= 4; i++) begin
      drive1(1, 16'h0100 + CW'(i), DW'(i));
      tick();
      chk($sformatf("str_od%0d", i), od1, i);
      chk($sformatf("str_oc%0d", i), oc1, 16'h0100 + i);
      chk($sformatf("str_ov%0d", i), ov1, 1);
      chk($sformatf("str_occ%0d", i), occ1, 1);
      chk($sformatf("str_ir%0d", i), ir1, 1);
    end
    drive1(0, '0, '0);
    tick();
    chk("str_end_ov", ov1, 0);
    chk("str_end_oc", oc1, 0);
    chk("str_end_occ", occ1, 0);
    chk("str_end_od", od1, 4);

    // Backpressure
    or1 = 0;
    drive1(1, 16'h000A, DW'('hA));
    tick();
    chk("bp_A_occ", occ1, 1);
    chk("bp_A_od", od1, 'hA);
    chk("bp_A_stall", st1, 0);
    drive1(1, 16'h000B, DW'('hB));
    tick();
    chk("bp_B_occ", occ1, 2);
    chk("bp_B_ir", ir1, 0);
    chk("bp_B_od", od1, 'hA);
    chk("bp_B_stall", st1, 1);
    drive1(1, 16'h000C, DW'('hC));
    tick();
    chk("bp_C_occ", occ1, 2);
    chk("bp_C_od", od1, 'hA);
    chk("bp_C_stall", st1, 2);
    or1 = 1;
    tick();
    chk("bp_outB_od", od1, 'hB);
    chk("bp_outB_oc", oc1, 'hB);
    chk("bp_outB_occ", occ1, 1);
    chk("bp_outB_ir", ir1, 1);
    chk("bp_outB_stall", st1, 2);
    tick();
    chk("bp_outC_od", od1, 'hC);
    chk("bp_outC_occ", occ1, 1);
    drive1(0, '0, '0);
    tick();
    chk("bp_end_ov", ov1, 0);
    chk("bp_end_occ", occ1, 0);

    // Flush at occupancy 2 with a payload presented
    or1 = 0;
    drive1(1, 16'h000D, DW'('hD));
    tick();
    drive1(1, 16'h000E, DW'('hE));
    tick();
    chk("fl_pre_occ", occ1, 2);
    chk("fl_pre_stall", st1, 3);
    f1 = 1;
    drive1(1, 16'hFFFF, DW'('hF));
    tick();
    f1 = 0;
    chk("fl_occ", occ1, 0);
    chk("fl_ov", ov1, 0);
    chk("fl_oc", oc1, 0);
    chk("fl_ir", ir1, 1);
    chk("fl_od_kept", od1, 'hD);
    chk("fl_stall_kept", st1, 4);
    or1 = 1;
    drive1(1, 16'h0033, DW'('h77));
    tick();
    chk("fl_next_od", od1, 'h77);
    chk("fl_next_oc", oc1, 'h33);
    chk("fl_next_occ", occ1, 1);
    drive1(0, '0, '0);
    tick();
    chk("fl_drain_occ", occ1, 0);

    // Async reset at occupancy 2
    or1 = 0;
    drive1(1, 16'h0001, DW'('h1));
    tick();
    drive1(1, 16'h0002, DW'('h2));
    tick();
    drive1(0, '0, '0);
    chk("ar_pre_occ", occ1, 2);
    chk("ar_pre_stall", st1, 5);
    #2 reset = 1'b1;
    #1;
    chk("ar_occ", occ1, 0);
    chk("ar_ov", ov1, 0);
    chk("ar_oc", oc1, 0);
    chk("ar_od", od1, 0);
    chk("ar_stall", st1, 0);
    #1 reset = 1'b0;
    tick();
    chk("ar_post_ir", ir1, 1);
    chk("ar_post_occ", occ1, 0);
    chk("ar_post_stall", st1, 0);

    // SKID=0 with out_ready toggling 1,0,1
    or0 = 1; iv0 = 1; ic0 = 16'h0010; id0 = DW'('h10);
    #1;
    chk("s0_ir_empty", ir0, 1);
    tick();
    chk("s0_10_od", od0, 'h10);
    chk("s0_10_occ", occ0, 1);
    chk("s0_ir_full_rdy", ir0, 1);
    ic0 = 16'h0011; id0 = DW'('h11);
    tick();
    chk("s0_11_od", od0, 'h11);
    or0 = 0; ic0 = 16'h0012; id0 = DW'('h12);
    #1;
    chk("s0_ir_track0", ir0, 0);
    tick();
    chk("s0_hold_od", od0, 'h11);
    chk("s0_hold_occ", occ0, 1);
    chk("s0_stall", st0, 1);
    or0 = 1;
    #1;
    chk("s0_ir_track1", ir0, 1);
    tick();
    chk("s0_12_od", od0, 'h12);
    chk("s0_12_oc", oc0, 'h12);
    chk("s0_12_occ", occ0, 1);
    iv0 = 0;
    tick();
    chk("s0_end_occ", occ0, 0);
    chk("s0_end_ov", ov0, 0);
    chk("s0_end_oc", oc0, 0);

    // stall_cnt saturation: 70000 stalled cycles
    or1 = 0;
    drive1(1, 16'h0005, DW'('h5));
    tick();
    drive1(0, '0, '0);
    chk("sat_start", st1, 0);
    repeat (65534) tick();
    chk("sat_fffe", st1, 16'hFFFE);
    tick();
    chk("sat_ffff", st1, 16'hFFFF);
    repeat (4465) tick();
    chk("sat_nowrap", st1, 16'hFFFF);
    chk("sat_ov", ov1, 1);
    chk("sat_od", od1, 'h5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
